// File: rtl/reg32_load_pkg.sv
// Shared definitions for the parallel-load register: data width, bench clock
// timing and reset levels.
package reg32_load_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  // Half-period of the free-running bench clock, in time units.
  localparam int unsigned CLK_HALF_PERIOD = 5;

  localparam logic RST_ACTIVE   = 1'b0;
  localparam logic RST_INACTIVE = 1'b1;

  localparam logic [WIDTH_DEF-1:0] RESET_VALUE = '0;

endpackage : reg32_load_pkg

// File: rtl/reg32_load_reg1.sv
// One bit of the parallel-load register: a hold/load select feeding an
// edge-triggered flop with asynchronous active-low clear.
module reg32_load_reg1
  import reg32_load_pkg::*;
(
  output logic q_o,
  input  logic d_i,
  input  logic load_i,
  input  logic clk_i,
  input  logic rst_ni
);

  logic q_q;
  logic q_d;

  // An unknown D never reaches the flop unless load is actually high.
  always_comb begin
    q_d = q_q;
    if (load_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RST_ACTIVE) q_q <= 1'b0;
    else                      q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : reg32_load_reg1

// File: rtl/reg32_load.sv
// 32-bit parallel-load storage register used for the register file, PC, SP and
// similar datapath state. One independent bit cell per data bit.
module reg32_load
  import reg32_load_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             CLK,
  input  logic             RST
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg32_load_reg1 u_bit (
      .q_o    (Q[i]),
      .d_i    (D[i]),
      .load_i (LOAD),
      .clk_i  (CLK),
      .rst_ni (RST)
    );
  end

endmodule : reg32_load

// File: tb/tb_reg32_load.sv
// Directed bench for reg32_load: reset, load, hold, bit toggling, async reset
// and input activity between edges.
module tb_reg32_load;
  import reg32_load_pkg::*;

  logic [31:0] Q;
  logic [31:0] D;
  logic        LOAD;
  logic        CLK;
  logic        RST;

  int n_cmp = 0;
  int n_err = 0;

  reg32_load #(.WIDTH(32)) dut (
    .Q    (Q),
    .D    (D),
    .LOAD (LOAD),
    .CLK  (CLK),
    .RST  (RST)
  );

  initial CLK = 1'b0;
  always #(CLK_HALF_PERIOD) CLK = ~CLK;

  // Inputs change and outputs are sampled 1 unit after a rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD = 1'b0; D = '0;
    #2;
    RST = 1'b0; LOAD = 1'b1; D = 32'd24;
    #1;
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL reset_async: got %h want %h", Q, 32'h0); end
    step();
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL reset_edge_load: got %h want %h", Q, 32'h0); end
    LOAD = 1'b0;
    RST = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL reset_release_hold: got %h want %h", Q, 32'h0); end
  endtask

  task automatic test_load();
    D = 32'd24; LOAD = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'd24) begin n_err++; $display("FAIL load_24: got %h want %h", Q, 32'd24); end
  endtask

  task automatic test_hold();
    D = 32'd13; LOAD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (Q !== 32'd24) begin n_err++; $display("FAIL hold_%0d: got %h want %h", k, Q, 32'd24); end
    end
  endtask

  task automatic test_toggle();
    D = 32'd9; LOAD = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'd9) begin n_err++; $display("FAIL load_9: got %h want %h", Q, 32'd9); end
    D = 32'hFFFF_FFFF;
    step();
    n_cmp++;
    if (Q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL load_ones: got %h want %h", Q, 32'hFFFF_FFFF); end
    D = 32'h0;
    step();
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL load_zeros: got %h want %h", Q, 32'h0); end
    D = 32'h1234_5678;
    step();
    n_cmp++;
    if (Q !== 32'h1234_5678) begin n_err++; $display("FAIL load_mixed: got %h want %h", Q, 32'h1234_5678); end
  endtask

  task automatic test_async_reset();
    D = 32'hA5A5_5A5A; LOAD = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'hA5A5_5A5A) begin n_err++; $display("FAIL load_a5: got %h want %h", Q, 32'hA5A5_5A5A); end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL midcycle_reset: got %h want %h", Q, 32'h0); end
    D = 32'hFFFF_FFFF;
    step();
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL reset_holds_over_load: got %h want %h", Q, 32'h0); end
    LOAD = 1'b0;
    RST = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'h0) begin n_err++; $display("FAIL no_recovery_after_reset: got %h want %h", Q, 32'h0); end
  endtask

  task automatic test_between_edges();
    D = 32'hC3C3_3C3C; LOAD = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'hC3C3_3C3C) begin n_err++; $display("FAIL load_c3: got %h want %h", Q, 32'hC3C3_3C3C); end
    D = 32'h1111_1111; #1;
    LOAD = 1'b0;       #1;
    D = 32'h2222_2222; #1;
    LOAD = 1'b1;       #1;
    n_cmp++;
    if (Q !== 32'hC3C3_3C3C) begin n_err++; $display("FAIL no_edge_change: got %h want %h", Q, 32'hC3C3_3C3C); end
    LOAD = 1'b0;
    step();
    n_cmp++;
    if (Q !== 32'hC3C3_3C3C) begin n_err++; $display("FAIL hold_after_wiggle: got %h want %h", Q, 32'hC3C3_3C3C); end
  endtask

  task automatic test_x_hold();
    D = 'x; LOAD = 1'b0;
    step();
    n_cmp++;
    if (Q !== 32'hC3C3_3C3C) begin n_err++; $display("FAIL x_data_hold: got %h want %h", Q, 32'hC3C3_3C3C); end
    n_cmp++;
    if ($isunknown(Q)) begin n_err++; $display("FAIL x_data_clean: got %h want no unknown bits", Q); end
    D = 32'h0F0F_F0F0; LOAD = 1'b1;
    step();
    n_cmp++;
    if (Q !== 32'h0F0F_F0F0) begin n_err++; $display("FAIL load_after_x: got %h want %h", Q, 32'h0F0F_F0F0); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_toggle();
    test_async_reset();
    test_between_edges();
    test_x_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg32_load

// File: doc/reg32_load.md
# reg32_load

32-bit parallel-load storage register: the basic state element of the gate-level processor datapath, used for the register file, PC, SP and similar registers. On a rising clock edge it captures the data input when load is asserted and otherwise holds its contents. An asynchronous active-low reset clears it. Simulation benches drive it from the shared free-running clock source module.

## Interface
Parameters:
- WIDTH, 32, register width in bits; all data ports are WIDTH wide.

Ports, in positional order Q, D, LOAD, CLK, RST:
- CLK  input  1  system clock; the only clock; all state changes on its rising edge.
- RST  input  1  reset, asynchronous and active-low; 0 forces Q to zero immediately.
- Q  output  WIDTH  current stored value, driven continuously from the storage elements.
- D  input  WIDTH  parallel data to be captured.
- LOAD  input  1  active-high load enable, sampled on the rising edge of CLK.

## Operation
- RST=0: every bit of Q is 0, independent of CLK, LOAD and D.
- RST=1, rising CLK edge, LOAD=1: Q takes the value of D.
- RST=1, rising CLK edge, LOAD=0: Q keeps its previous value.
- Between rising edges, Q never changes, whatever D or LOAD do.
- Each bit is independent: a 2:1 select (LOAD ? D[i] : Q[i]) feeds one edge-triggered flip-flop with an asynchronous clear.
- If LOAD or D is X/Z while LOAD=0 or RST=0, Q must not be corrupted (no X propagation into a held or reset value).
- No arithmetic, no width conversion; Q[i] corresponds to D[i] bit for bit.

## Timing
- Reset value of Q: 32'h0000_0000.
- Reset assertion acts asynchronously. Q clears with no clock edge and stays cleared for as long as RST=0, including across rising edges with LOAD=1.
- Reset release: the first capture can occur on the first rising edge at which RST=1 and LOAD=1.
- Load latency: one edge. D sampled at rising edge k appears on Q immediately after edge k, within the same cycle, with no additional pipeline stage.
- Simultaneous events:
  - RST falling at a rising clock edge with LOAD=1: reset wins, Q=0.
  - RST rising coincident with an edge: that edge is ignored for capture.
- Reset mid-operation discards the stored value; there is no recovery of the old contents.

## Structure
- Shared package (the project definition include): WIDTH default (data width 32), clock half-period constant, and reset-level constants.
- One natural sub-module, reg1: a 1-bit load-enabled register (2:1 mux plus rising-edge D flip-flop with async active-low clear). The top instantiates WIDTH copies via generate.
- The flip-flop may itself be built as a master/slave latch pair from basic gates, consistent with the gate-level datapath.
- The clock source is a separate non-synthesizable bench module that drives a free-running CLK with period 2× the half-period constant. It is not part of this block's RTL.

## Test plan
- Hold RST=0 for a clock edge with LOAD=1 and D=24 -> Q=0 throughout. Release RST=1 -> Q stays 0 until a loading edge.
- RST=1, D=24, LOAD=1, one rising edge -> Q=24.
- Then D=13, LOAD=0 across several edges -> Q stays 24.
- Then D=9, LOAD=1, one rising edge -> Q=9. D=32'hFFFF_FFFF, LOAD=1 -> Q=32'hFFFF_FFFF. Then D=32'h0 -> Q=0 (every bit toggles both ways).
- With Q=32'hA5A5_5A5A, drop RST to 0 mid-cycle (no edge) -> Q=0 immediately. Keep LOAD=1 across an edge -> Q remains 0.
- Toggle D and LOAD between edges without a rising edge -> Q unchanged. D=X with LOAD=0 at an edge -> Q unchanged and free of X.
